// File: rtl/lif_tdm_scheduler_pkg.sv
// rtl/lif_tdm_scheduler_pkg.sv - shared FSM states, default widths and saturating add for the LIF scheduler
package lif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_EMIT,
    ST_DONE
  } lif_state_e;

  localparam int DEF_NUM_NEURONS   = 4;
  localparam int DEF_STATE_W       = 8;
  localparam int DEF_CUR_W         = 4;
  localparam int DEF_LEAK_SHIFT    = 3;
  localparam int DEF_REFRACT_TICKS = 2;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    logic [31:0] res;
    sum = {1'b0, a} + {1'b0, b};
    res = (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    return res;
  endfunction

endpackage

// File: rtl/lif_tdm_scheduler_if.sv
// rtl/lif_tdm_scheduler_if.sv - spike event valid/ready stream between scheduler and consumer
interface lif_tdm_scheduler_if #(
  parameter int IDX_W = 2
);
  logic             spike_valid;
  logic             spike_ready;
  logic [IDX_W-1:0] spike_idx;

  modport master(output spike_valid, output spike_idx, input spike_ready);
  modport slave(input spike_valid, input spike_idx, output spike_ready);
endinterface

// File: rtl/lif_tdm_scheduler_update.sv
// rtl/lif_tdm_scheduler_update.sv - combinational leak/integrate/saturate/compare for one neuron
module lif_update
  import lif_pkg::*;
#(
  parameter int STATE_W    = DEF_STATE_W,
  parameter int CUR_W      = DEF_CUR_W,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
  input  logic [STATE_W-1:0] s,
  input  logic [CUR_W-1:0]   cur,
  input  logic [STATE_W-1:0] thresh,
  input  logic               inhibit,
  output logic [STATE_W-1:0] next_s,
  output logic               spike
);
  localparam logic [31:0] MAX_S = 32'((64'd1 << STATE_W) - 64'd1);

  logic [31:0] leaked;
  logic [31:0] cur_ext;
  logic [31:0] sum;

  assign leaked  = 32'(s - (s >> LEAK_SHIFT));
  // A refractory neuron still leaks but integrates nothing and cannot fire.
  assign cur_ext = inhibit ? 32'd0 : 32'(cur);
  assign sum     = sat_add(leaked, cur_ext, MAX_S);
  assign spike   = !inhibit && (sum >= 32'(thresh));
  assign next_s  = spike ? '0 : STATE_W'(sum);
endmodule

// File: rtl/lif_tdm_scheduler.sv
// rtl/lif_tdm_scheduler.sv - TDM LIF sweep scheduler; optional refractory counters under LIF_REFRACTORY_EN
module lif_tdm_scheduler
  import lif_pkg::*;
#(
  parameter int NUM_NEURONS   = DEF_NUM_NEURONS,
  parameter int STATE_W       = DEF_STATE_W,
  parameter int CUR_W         = DEF_CUR_W,
  parameter int LEAK_SHIFT    = DEF_LEAK_SHIFT,
  parameter int REFRACT_TICKS = DEF_REFRACT_TICKS,
  localparam int IDX_W        = $clog2(NUM_NEURONS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic [STATE_W-1:0]           thresh,
  input  logic [NUM_NEURONS*CUR_W-1:0] cur_in,
  lif_tdm_scheduler_if.master          spk,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun,
  input  logic [IDX_W-1:0]             dbg_sel,
  output logic [STATE_W-1:0]           dbg_state
);
  lif_state_e                   state_q, state_d;
  logic [IDX_W-1:0]             idx_q;
  logic [IDX_W-1:0]             spike_idx_q;
  logic [STATE_W-1:0]           thresh_q;
  logic [NUM_NEURONS*CUR_W-1:0] cur_q;
  logic [STATE_W-1:0]           mem [NUM_NEURONS];
  logic                         overrun_q;
  logic                         last;
  logic                         inhibit;
  logic                         spike;
  logic [STATE_W-1:0]           next_s;
  logic [CUR_W-1:0]             cur_sel;

  assign last    = (idx_q == IDX_W'(NUM_NEURONS - 1));
  assign cur_sel = cur_q[idx_q*CUR_W +: CUR_W];

  lif_update #(
    .STATE_W   (STATE_W),
    .CUR_W     (CUR_W),
    .LEAK_SHIFT(LEAK_SHIFT)
  ) u_update (
    .s      (mem[idx_q]),
    .cur    (cur_sel),
    .thresh (thresh_q),
    .inhibit(inhibit),
    .next_s (next_s),
    .spike  (spike)
  );

`ifdef LIF_REFRACTORY_EN
  localparam int RC_W = $clog2(REFRACT_TICKS + 1);
  logic [RC_W-1:0] rc_q [NUM_NEURONS];

  assign inhibit = (rc_q[idx_q] != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) rc_q[i] <= '0;
    end else if (state_q == ST_UPDATE) begin
      if (inhibit) rc_q[idx_q] <= rc_q[idx_q] - 1'b1;
      else if (spike) rc_q[idx_q] <= RC_W'(REFRACT_TICKS);
    end
  end
`else
  assign inhibit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (tick) state_d = ST_UPDATE;
      ST_UPDATE: begin
        if (spike) state_d = ST_EMIT;
        else if (last) state_d = ST_DONE;
      end
      ST_EMIT:   if (spk.spike_ready) state_d = last ? ST_DONE : ST_UPDATE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign spk.spike_valid = (state_q == ST_EMIT);
  assign spk.spike_idx   = spike_idx_q;
  assign busy            = (state_q == ST_UPDATE) || (state_q == ST_EMIT);
  assign done            = (state_q == ST_DONE);
  assign overrun         = overrun_q;
  assign dbg_state       = mem[dbg_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      spike_idx_q <= '0;
      thresh_q    <= '0;
      cur_q       <= '0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) mem[i] <= '0;
    end else begin
      state_q <= state_d;
      if (tick && state_q != ST_IDLE) overrun_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            thresh_q <= thresh;
            cur_q    <= cur_in;
            idx_q    <= '0;
          end
        end
        ST_UPDATE: begin
          mem[idx_q] <= next_s;
          if (spike) spike_idx_q <= idx_q;
          else if (!last) idx_q <= idx_q + 1'b1;
        end
        ST_EMIT: begin
          if (spk.spike_ready && !last) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// tb/tb_lif_tdm_scheduler.sv - self-checking bench: vector table, corner sequences, randomized sweeps vs reference model
module tb_lif_tdm_scheduler;
  localparam int N  = 4;
  localparam int SW = 8;
  localparam int CW = 4;
  localparam int LS = 3;
  localparam int RT = 2;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [SW-1:0] thresh;
  logic [N*CW-1:0] cur_in;
  logic          busy, done, overrun;
  logic [IW-1:0] dbg_sel;
  logic [SW-1:0] dbg_state;

  lif_tdm_scheduler_if #(.IDX_W(IW)) bus ();

  lif_tdm_scheduler #(
    .NUM_NEURONS  (N),
    .STATE_W      (SW),
    .CUR_W        (CW),
    .LEAK_SHIFT   (LS),
    .REFRACT_TICKS(RT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .thresh   (thresh),
    .cur_in   (cur_in),
    .spk      (bus),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun),
    .dbg_sel  (dbg_sel),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int model_s[N];
  int model_r[N];
  int exp_ev[$];
  int got_ev[$];

  typedef struct {
    logic [7:0]  thr;
    logic [15:0] cur;
    logic [3:0]  mask;
    logic [31:0] st;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      model_s[i] = 0;
      model_r[i] = 0;
    end
  endfunction

  // Reference: plain integer arithmetic over one full sweep.
  function automatic void model_sweep(input int thr, input logic [15:0] cur);
    exp_ev.delete();
    for (int i = 0; i < N; i++) begin
      int c, sum;
      bit inh;
      c = int'(cur[i*CW +: CW]);
      inh = (model_r[i] > 0);
      if (inh) begin
        c = 0;
        model_r[i]--;
      end
      sum = model_s[i] - (model_s[i] / (1 << LS)) + c;
      if (sum > 255) sum = 255;
      if (!inh && sum >= thr) begin
        model_s[i] = 0;
        exp_ev.push_back(i);
`ifdef LIF_REFRACTORY_EN
        model_r[i] = RT;
`endif
      end else begin
        model_s[i] = sum;
      end
    end
  endfunction

  task automatic read_state(input int i, output int v);
    dbg_sel = IW'(i);
    #1;
    v = int'(dbg_state);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick = 1'b0;
    bus.spike_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic sweep(input logic [7:0] thr, input logic [15:0] cur, input bit rnd,
                       output int lat, output int gap);
    int last_hs;
    got_ev.delete();
    lat = -1;
    gap = -1;
    last_hs = -1;
    thresh = thr;
    cur_in = cur;
    tick = 1'b1;
    bus.spike_ready = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    for (int c = 0; c < 200; c++) begin
      bus.spike_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (done) begin
        lat = c;
        if (last_hs >= 0) gap = c - last_hs;
        break;
      end
      if (bus.spike_valid && bus.spike_ready) begin
        got_ev.push_back(int'(bus.spike_idx));
        last_hs = c;
      end
      @(posedge clk);
      #1;
    end
    if (lat < 0) check("sweep_timeout", 0, 1);
    bus.spike_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag);
    int v;
    check({tag, "_nev"}, got_ev.size(), exp_ev.size());
    for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++)
      check({tag, "_idx"}, got_ev[i], exp_ev[i]);
    for (int i = 0; i < N; i++) begin
      read_state(i, v);
      check({tag, "_state"}, v, model_s[i]);
    end
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.spike_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({tag, "_valid_seen"}, int'(seen), 1);
  endtask

  initial begin
    int lat, gap, v, mask, ndone;
    logic [15:0] rc;
    logic [7:0]  rt;

    rst = 1'b1;
    tick = 1'b0;
    thresh = '0;
    cur_in = '0;
    dbg_sel = '0;
    bus.spike_ready = 1'b1;

    tbl[0] = '{8'd20,  16'h0000, 4'b0000, 32'h00000000};
    tbl[1] = '{8'd10,  16'h9A5F, 4'b0101, 32'h09000500};
    tbl[2] = '{8'd0,   16'h7130, 4'b1111, 32'h00000000};
    tbl[3] = '{8'd255, 16'hFFFF, 4'b0000, 32'h0F0F0F0F};
    tbl[4] = '{8'd15,  16'hEF0F, 4'b0101, 32'h0E000000};

    // Reset state and idle sweep latency
    do_reset();
    check("rst_valid", int'(bus.spike_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_idx", int'(bus.spike_idx), 0);
    sweep(8'd20, 16'h0000, 1'b0, lat, gap);
    check("idle_latency", lat, N);
    check("idle_nev", got_ev.size(), 0);
    check("done_one_cycle", int'(done), 0);
    check("idle_busy_after", int'(busy), 0);
    for (int i = 0; i < N; i++) begin
      read_state(i, v);
      check("idle_state", v, 0);
    end

    // Vector table, each from reset
    for (int t = 0; t < 5; t++) begin
      do_reset();
      sweep(tbl[t].thr, tbl[t].cur, 1'b0, lat, gap);
      mask = 0;
      foreach (got_ev[k]) mask |= (1 << got_ev[k]);
      check("tbl_mask", mask, int'(tbl[t].mask));
      check("tbl_nev", got_ev.size(), $countones(tbl[t].mask));
      for (int i = 0; i < N; i++) begin
        read_state(i, v);
        check("tbl_state", v, int'(tbl[t].st[i*8 +: 8]));
      end
    end

    // Integrate across two sweeps, then fire
    do_reset();
    sweep(8'd20, 16'h000F, 1'b0, lat, gap);
    model_sweep(20, 16'h000F);
    read_state(0, v);
    check("two_tick_s0_first", v, 15);
    check_result("two_tick_1");
    sweep(8'd20, 16'h000F, 1'b0, lat, gap);
    model_sweep(20, 16'h000F);
    check("two_tick_nev", got_ev.size(), 1);
    if (got_ev.size() > 0) check("two_tick_idx", got_ev[0], 0);
    check_result("two_tick_2");

    // Threshold zero: all fire in order, done right after last handshake
    do_reset();
    sweep(8'd0, 16'h1234, 1'b0, lat, gap);
    check("thr0_nev", got_ev.size(), 4);
    for (int i = 0; i < got_ev.size(); i++) check("thr0_order", got_ev[i], i);
    check("thr0_done_gap", gap, 1);

    // Backpressure holds the event
    do_reset();
    thresh = 8'd0;
    cur_in = 16'h0000;
    tick = 1'b1;
    bus.spike_ready = 1'b0;
    @(posedge clk);
    #1;
    tick = 1'b0;
    wait_valid("bp");
    for (int c = 0; c < 3; c++) begin
      check("bp_valid", int'(bus.spike_valid), 1);
      check("bp_idx", int'(bus.spike_idx), 0);
      check("bp_busy", int'(busy), 1);
      read_state(1, v);
      @(posedge clk);
      #1;
    end
    bus.spike_ready = 1'b1;
    @(posedge clk);
    #1;
    wait_valid("bp_next");
    check("bp_next_idx", int'(bus.spike_idx), 1);
    ndone = 0;
    for (int c = 0; c < 20 && ndone == 0; c++) begin
      if (done) ndone++;
      @(posedge clk);
      #1;
    end
    check("bp_done", ndone, 1);

    // Tick during UPDATE sets overrun, sweep runs to one done
    do_reset();
    thresh = 8'd20;
    cur_in = 16'h5555;
    tick = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_busy", int'(busy), 1);
    @(posedge clk);
    #1;
    tick = 1'b0;
    check("ovr_flag", int'(overrun), 1);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) ndone++;
      @(posedge clk);
      #1;
    end
    check("ovr_ndone", ndone, 1);
    check("ovr_sticky", int'(overrun), 1);
    model_sweep(20, 16'h5555);
    got_ev.delete();
    check_result("ovr");

    // Reset mid-EMIT drops the event and clears everything
    thresh = 8'd0;
    tick = 1'b1;
    bus.spike_ready = 1'b0;
    @(posedge clk);
    #1;
    tick = 1'b0;
    wait_valid("rst_emit");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.spike_ready = 1'b1;
    model_reset();
    check("rme_valid", int'(bus.spike_valid), 0);
    check("rme_busy", int'(busy), 0);
    check("rme_overrun", int'(overrun), 0);
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      if (done) ndone++;
      @(posedge clk);
      #1;
    end
    check("rme_ndone", ndone, 0);
    for (int i = 0; i < N; i++) begin
      read_state(i, v);
      check("rme_state", v, 0);
    end

`ifdef LIF_REFRACTORY_EN
    // Refractory: fire, skip two sweeps, fire again
    do_reset();
    for (int s = 1; s <= 4; s++) begin
      sweep(8'd10, 16'h000F, 1'b0, lat, gap);
      model_sweep(10, 16'h000F);
      check("refr_nev", got_ev.size(), (s == 1 || s == 4) ? 1 : 0);
      read_state(0, v);
      check("refr_s0", v, 0);
      check_result("refr");
    end
`endif

    // Randomized sweeps against the reference model
    do_reset();
    for (int s = 0; s < 40; s++) begin
      rt = 8'($urandom_range(0, 80));
      rc = 16'($urandom);
      sweep(rt, rc, 1'b1, lat, gap);
      model_sweep(int'(rt), rc);
      check_result("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
